// File: rtl/cv32e40x_wb_stage_if.sv
// Writeback-stage port bundle: EX/WB pipeline register contents, controller
// kill, LSU response channel and the writeback results/handshake.
//
// Handshake: EX presents an instruction with ex_wb_valid_i. WB accepts it in
// the cycle wb_ready_o=1. While wb_ready_o=0 the EX/WB register is held stable.
// The LSU response (lsu_rvalid_i) is a single-cycle pulse that WB always
// consumes; it has no back-pressure.
interface cv32e40x_wb_stage_if;
  logic        ex_wb_valid_i;
  logic        ex_wb_rf_we_i;
  logic [4:0]  ex_wb_rf_waddr_i;
  logic [31:0] ex_wb_rf_wdata_i;
  logic        ex_wb_data_req_i;
  logic        ex_wb_exc_i;
  logic [31:0] ex_wb_pc_i;
  logic        kill_wb_i;
  logic        lsu_rvalid_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_err_i;
  logic        rf_we_wb_o;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        wb_ready_o;
  logic        wb_valid_o;
  logic        lsu_err_o;
  logic [31:0] lsu_err_pc_o;
  logic [63:0] instret_o;

  // Pipeline/LSU/controller side
  modport master (
    output ex_wb_valid_i, ex_wb_rf_we_i, ex_wb_rf_waddr_i, ex_wb_rf_wdata_i,
           ex_wb_data_req_i, ex_wb_exc_i, ex_wb_pc_i, kill_wb_i,
           lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    input  rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, wb_ready_o, wb_valid_o,
           lsu_err_o, lsu_err_pc_o, instret_o
  );

  // Writeback stage side
  modport slave (
    input  ex_wb_valid_i, ex_wb_rf_we_i, ex_wb_rf_waddr_i, ex_wb_rf_wdata_i,
           ex_wb_data_req_i, ex_wb_exc_i, ex_wb_pc_i, kill_wb_i,
           lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    output rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, wb_ready_o, wb_valid_o,
           lsu_err_o, lsu_err_pc_o, instret_o
  );
endinterface

// File: rtl/cv32e40x_wb_stage.sv
// Writeback stage: commits ALU results immediately, completes loads on the
// LSU response, reports load bus errors and counts retired instructions.
// A load killed before its response arrives parks in DRAIN so the late
// response is swallowed instead of being attributed to a younger instruction.
module cv32e40x_wb_stage (
  input  logic                     clk,
  input  logic                     rst_n,
  cv32e40x_wb_stage_if.slave       wb_if,
  output logic [1:0]               wb_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } wb_state_e;

  wb_state_e   state_q, state_d;
  logic [63:0] instret_q;

  logic act;
  logic ld;
  logic rf_we;
  logic retire;
  logic err;
  logic ready;

  assign act = wb_if.ex_wb_valid_i && !wb_if.kill_wb_i;
  assign ld  = act && wb_if.ex_wb_data_req_i;

  // Next-state and writeback control; everything defaults to "nothing happens"
  always_comb begin
    state_d = state_q;
    rf_we   = 1'b0;
    retire  = 1'b0;
    err     = 1'b0;
    ready   = 1'b1;
    case (state_q)
      IDLE: begin
        if (act && !wb_if.ex_wb_data_req_i) begin
          rf_we  = wb_if.ex_wb_rf_we_i && !wb_if.ex_wb_exc_i;
          retire = !wb_if.ex_wb_exc_i;
        end else if (ld) begin
          if (wb_if.lsu_rvalid_i) begin
            // Zero-wait response completes without leaving IDLE
            if (wb_if.lsu_err_i) begin
              err = 1'b1;
            end else begin
              rf_we  = wb_if.ex_wb_rf_we_i;
              retire = 1'b1;
            end
          end else begin
            ready   = 1'b0;
            state_d = WAIT;
          end
        end
        // Killed or absent instruction: no side effects, stay ready
      end
      WAIT: begin
        if (wb_if.lsu_rvalid_i) begin
          state_d = IDLE;
          if (wb_if.kill_wb_i) begin
            // Response consumed and discarded
          end else if (wb_if.lsu_err_i) begin
            err = 1'b1;
          end else begin
            rf_we  = wb_if.ex_wb_rf_we_i;
            retire = 1'b1;
          end
        end else begin
          ready = 1'b0;
          if (wb_if.kill_wb_i) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Swallow the orphaned response; block any new instruction meanwhile
        ready = 1'b0;
        if (wb_if.lsu_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, wraps modulo 2^64
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign wb_if.rf_we_wb_o    = rf_we;
  assign wb_if.rf_waddr_wb_o = wb_if.ex_wb_rf_waddr_i;
  assign wb_if.rf_wdata_wb_o = wb_if.ex_wb_data_req_i ? wb_if.lsu_rdata_i
                                                      : wb_if.ex_wb_rf_wdata_i;
  assign wb_if.wb_ready_o    = ready;
  assign wb_if.wb_valid_o    = retire;
  assign wb_if.lsu_err_o     = err;
  assign wb_if.lsu_err_pc_o  = wb_if.ex_wb_pc_i;
  assign wb_if.instret_o     = instret_q;
  assign wb_state_o          = state_q;

endmodule

// File: tb/tb_cv32e40x_wb_stage.sv
// Directed bench for the writeback stage.
module tb_cv32e40x_wb_stage;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] wb_state;
  int         checks;
  int         errors;

  cv32e40x_wb_stage_if wb_if ();

  cv32e40x_wb_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_if      (wb_if),
    .wb_state_o (wb_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // An LSU response must never show up in IDLE without a load present
  always @(negedge clk) begin
    if (rst_n && wb_state == S_IDLE && wb_if.lsu_rvalid_i) begin
      assert (wb_if.ex_wb_valid_i && wb_if.ex_wb_data_req_i) else begin
        errors++;
        $error("FAIL protocol rvalid in IDLE without load");
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wb_if.ex_wb_valid_i    = 1'b0;
    wb_if.ex_wb_rf_we_i    = 1'b0;
    wb_if.ex_wb_rf_waddr_i = 5'd0;
    wb_if.ex_wb_rf_wdata_i = 32'd0;
    wb_if.ex_wb_data_req_i = 1'b0;
    wb_if.ex_wb_exc_i      = 1'b0;
    wb_if.ex_wb_pc_i       = 32'd0;
    wb_if.kill_wb_i        = 1'b0;
    wb_if.lsu_rvalid_i     = 1'b0;
    wb_if.lsu_rdata_i      = 32'd0;
    wb_if.lsu_err_i        = 1'b0;
  endtask

  task automatic drive_op(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic data_req, input logic exc, input logic [31:0] pc);
    wb_if.ex_wb_valid_i    = 1'b1;
    wb_if.ex_wb_rf_we_i    = we;
    wb_if.ex_wb_rf_waddr_i = waddr;
    wb_if.ex_wb_rf_wdata_i = wdata;
    wb_if.ex_wb_data_req_i = data_req;
    wb_if.ex_wb_exc_i      = exc;
    wb_if.ex_wb_pc_i       = pc;
  endtask

  task automatic drive_rsp(input logic rvalid, input logic [31:0] rdata, input logic err);
    wb_if.lsu_rvalid_i = rvalid;
    wb_if.lsu_rdata_i  = rdata;
    wb_if.lsu_err_i    = err;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle();

    // Reset state
    #2;
    chk("rst_ready", 64'(wb_if.wb_ready_o), 64'd1);
    chk("rst_we", 64'(wb_if.rf_we_wb_o), 64'd0);
    chk("rst_valid", 64'(wb_if.wb_valid_o), 64'd0);
    chk("rst_err", 64'(wb_if.lsu_err_o), 64'd0);
    chk("rst_instret", wb_if.instret_o, 64'd0);
    chk("rst_state", 64'(wb_state), 64'(S_IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    // ALU op completes in the entry cycle
    drive_op(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 32'h10);
    #2;
    chk("alu_we", 64'(wb_if.rf_we_wb_o), 64'd1);
    chk("alu_waddr", 64'(wb_if.rf_waddr_wb_o), 64'd5);
    chk("alu_wdata", 64'(wb_if.rf_wdata_wb_o), 64'h1234);
    chk("alu_valid", 64'(wb_if.wb_valid_o), 64'd1);
    chk("alu_ready", 64'(wb_if.wb_ready_o), 64'd1);
    tick();
    drive_idle();
    chk("alu_instret", wb_if.instret_o, 64'd1);

    // Load with response three cycles after entry
    drive_op(1'b1, 5'd10, 32'h5555_5555, 1'b1, 1'b0, 32'h20);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("ld_stall_ready", 64'(wb_if.wb_ready_o), 64'd0);
      chk("ld_stall_we", 64'(wb_if.rf_we_wb_o), 64'd0);
      tick();
      chk("ld_wait_state", 64'(wb_state), 64'(S_WAIT));
    end
    drive_rsp(1'b1, 32'hDEAD_BEEF, 1'b0);
    #2;
    chk("ld_we", 64'(wb_if.rf_we_wb_o), 64'd1);
    chk("ld_waddr", 64'(wb_if.rf_waddr_wb_o), 64'd10);
    chk("ld_wdata", 64'(wb_if.rf_wdata_wb_o), 64'hDEAD_BEEF);
    chk("ld_ready", 64'(wb_if.wb_ready_o), 64'd1);
    chk("ld_valid", 64'(wb_if.wb_valid_o), 64'd1);
    tick();
    drive_idle();
    chk("ld_state_idle", 64'(wb_state), 64'(S_IDLE));
    chk("ld_instret", wb_if.instret_o, 64'd2);

    // Zero-wait load
    drive_op(1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 32'h24);
    drive_rsp(1'b1, 32'hCAFE_F00D, 1'b0);
    #2;
    chk("zw_we", 64'(wb_if.rf_we_wb_o), 64'd1);
    chk("zw_wdata", 64'(wb_if.rf_wdata_wb_o), 64'hCAFE_F00D);
    chk("zw_ready", 64'(wb_if.wb_ready_o), 64'd1);
    tick();
    drive_idle();
    chk("zw_state", 64'(wb_state), 64'(S_IDLE));
    chk("zw_instret", wb_if.instret_o, 64'd3);

    // Faulting load at pc 0x80
    drive_op(1'b1, 5'd8, 32'h0, 1'b1, 1'b0, 32'h80);
    #2;
    chk("err_entry_ready", 64'(wb_if.wb_ready_o), 64'd0);
    tick();
    drive_rsp(1'b1, 32'h1111_2222, 1'b1);
    #2;
    chk("err_we", 64'(wb_if.rf_we_wb_o), 64'd0);
    chk("err_pulse", 64'(wb_if.lsu_err_o), 64'd1);
    chk("err_pc", 64'(wb_if.lsu_err_pc_o), 64'h80);
    chk("err_valid", 64'(wb_if.wb_valid_o), 64'd0);
    chk("err_ready", 64'(wb_if.wb_ready_o), 64'd1);
    tick();
    drive_idle();
    chk("err_instret", wb_if.instret_o, 64'd3);
    chk("err_state", 64'(wb_state), 64'(S_IDLE));

    // Kill in WAIT, response arrives later while in DRAIN
    drive_op(1'b1, 5'd9, 32'h0, 1'b1, 1'b0, 32'h30);
    tick();
    chk("kill_wait_state", 64'(wb_state), 64'(S_WAIT));
    wb_if.kill_wb_i = 1'b1;
    #2;
    chk("kill_ready", 64'(wb_if.wb_ready_o), 64'd0);
    chk("kill_we", 64'(wb_if.rf_we_wb_o), 64'd0);
    tick();
    chk("drain_state", 64'(wb_state), 64'(S_DRAIN));
    drive_idle();
    drive_op(1'b1, 5'd3, 32'h77, 1'b0, 1'b0, 32'h34);
    #2;
    chk("drain_ready", 64'(wb_if.wb_ready_o), 64'd0);
    chk("drain_we", 64'(wb_if.rf_we_wb_o), 64'd0);
    chk("drain_valid", 64'(wb_if.wb_valid_o), 64'd0);
    tick();
    drive_rsp(1'b1, 32'hBAD0_BAD0, 1'b1);
    #2;
    chk("drain_rsp_ready", 64'(wb_if.wb_ready_o), 64'd0);
    chk("drain_rsp_we", 64'(wb_if.rf_we_wb_o), 64'd0);
    chk("drain_rsp_err", 64'(wb_if.lsu_err_o), 64'd0);
    tick();
    drive_rsp(1'b0, 32'h0, 1'b0);
    chk("drain_exit_state", 64'(wb_state), 64'(S_IDLE));
    chk("drain_instret", wb_if.instret_o, 64'd3);
    #2;
    chk("post_drain_we", 64'(wb_if.rf_we_wb_o), 64'd1);
    chk("post_drain_wdata", 64'(wb_if.rf_wdata_wb_o), 64'h77);
    chk("post_drain_valid", 64'(wb_if.wb_valid_o), 64'd1);
    tick();
    drive_idle();
    chk("post_drain_instret", wb_if.instret_o, 64'd4);

    // Kill together with the response in WAIT
    drive_op(1'b1, 5'd11, 32'h0, 1'b1, 1'b0, 32'h40);
    tick();
    wb_if.kill_wb_i = 1'b1;
    drive_rsp(1'b1, 32'h0BAD_0BAD, 1'b1);
    #2;
    chk("kr_we", 64'(wb_if.rf_we_wb_o), 64'd0);
    chk("kr_err", 64'(wb_if.lsu_err_o), 64'd0);
    chk("kr_valid", 64'(wb_if.wb_valid_o), 64'd0);
    chk("kr_ready", 64'(wb_if.wb_ready_o), 64'd1);
    tick();
    drive_idle();
    chk("kr_state", 64'(wb_state), 64'(S_IDLE));
    chk("kr_instret", wb_if.instret_o, 64'd4);

    // Killed ALU op in IDLE
    drive_op(1'b1, 5'd12, 32'h99, 1'b0, 1'b0, 32'h44);
    wb_if.kill_wb_i = 1'b1;
    #2;
    chk("kidle_we", 64'(wb_if.rf_we_wb_o), 64'd0);
    chk("kidle_valid", 64'(wb_if.wb_valid_o), 64'd0);
    chk("kidle_ready", 64'(wb_if.wb_ready_o), 64'd1);
    tick();
    drive_idle();
    chk("kidle_instret", wb_if.instret_o, 64'd4);

    // Counter wrap
    dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    drive_op(1'b1, 5'd1, 32'h1, 1'b0, 1'b0, 32'h50);
    tick();
    drive_idle();
    chk("wrap_instret", wb_if.instret_o, 64'd0);

    // Exception: no write, no retire
    drive_op(1'b1, 5'd2, 32'h2, 1'b0, 1'b1, 32'h54);
    #2;
    chk("exc_we", 64'(wb_if.rf_we_wb_o), 64'd0);
    chk("exc_valid", 64'(wb_if.wb_valid_o), 64'd0);
    chk("exc_ready", 64'(wb_if.wb_ready_o), 64'd1);
    tick();
    drive_idle();
    chk("exc_instret", wb_if.instret_o, 64'd0);

    // Reset while a load waits
    drive_op(1'b1, 5'd4, 32'h4, 1'b0, 1'b0, 32'h58);
    tick();
    chk("pre_rst_instret", wb_if.instret_o, 64'd1);
    drive_op(1'b1, 5'd6, 32'h0, 1'b1, 1'b0, 32'h5C);
    tick();
    chk("pre_rst_state", 64'(wb_state), 64'(S_WAIT));
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 64'(wb_state), 64'(S_IDLE));
    chk("midrst_instret", wb_if.instret_o, 64'd0);
    drive_idle();
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40x_wb_stage.md
# cv32e40x_wb_stage

Writeback stage of the cv32e40x pipeline; it consumes the EX/WB pipeline register that the execute stage produces. It commits results to the register file and completes loads by waiting for the LSU data response. It reports load bus errors and counts retired instructions. It drives `wb_ready_o` back to EX, which holds its EX/WB register while WB is stalled.

## Interface
Parameters: none.

Ports (single clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_wb_valid_i  in  1  EX/WB register holds a valid instruction (instr_valid)
- ex_wb_rf_we_i  in  1  instruction writes rd
- ex_wb_rf_waddr_i  in  5  destination register
- ex_wb_rf_wdata_i  in  32  ALU/MULT/CSR result; ignored for loads
- ex_wb_data_req_i  in  1  instruction is a load (result comes from LSU)
- ex_wb_exc_i  in  1  OR of illegal/ebrk/ecall flags from EX/WB
- ex_wb_pc_i  in  32  instruction PC
- kill_wb_i  in  1  controller flush of the WB instruction
- lsu_rvalid_i  in  1  LSU data response valid
- lsu_rdata_i  in  32  load data
- lsu_err_i  in  1  bus error on response; qualified by lsu_rvalid_i
- rf_we_wb_o  out  1  register file write enable
- rf_waddr_wb_o  out  5  register file write address
- rf_wdata_wb_o  out  32  register file write data (also the forwarding source to ID)
- wb_ready_o  out  1  WB can accept a new instruction this cycle
- wb_valid_o  out  1  one-cycle pulse: instruction retired
- lsu_err_o  out  1  one-cycle pulse: load completed with bus error
- lsu_err_pc_o  out  32  PC of the faulting load; valid while lsu_err_o=1
- instret_o  out  64  retired-instruction count

## Operation
- States are IDLE, WAIT, and DRAIN. A 2-bit state register resets to IDLE.
- Define act = ex_wb_valid_i && !kill_wb_i, and ld = act && ex_wb_data_req_i.
- IDLE, non-load (act && !data_req):
  - Completes in the same cycle.
  - rf_we_wb_o = rf_we && !exc. rf_wdata_wb_o = ex_wb_rf_wdata_i.
  - wb_valid_o = !exc. wb_ready_o = 1.
- IDLE, load with lsu_rvalid_i=1 (zero-wait response): completes in that cycle as for WAIT+rvalid. The state stays IDLE.
- IDLE, load with lsu_rvalid_i=0: wb_ready_o=0 and there is no write. Next state is WAIT.
- WAIT, lsu_rvalid_i=0: wb_ready_o=0 and there is no write.
- WAIT, lsu_rvalid_i=1, lsu_err_i=0:
  - rf_we_wb_o = rf_we. rf_wdata_wb_o = lsu_rdata_i.
  - wb_valid_o=1, wb_ready_o=1. Next state is IDLE.
- WAIT, lsu_rvalid_i=1, lsu_err_i=1:
  - No write, wb_valid_o=0.
  - lsu_err_o=1 with lsu_err_pc_o = ex_wb_pc_i.
  - wb_ready_o=1. Next state is IDLE.
- WAIT, kill_wb_i=1, lsu_rvalid_i=0: no write, wb_ready_o=0. Next state is DRAIN, because the response must still be consumed.
- Kill together with rvalid, in IDLE or WAIT: the response is consumed and discarded. No write, no error, wb_valid_o=0, wb_ready_o=1. Next state is IDLE.
- DRAIN:
  - wb_ready_o=0, with no writes, retires or errors, regardless of ex_wb_valid_i.
  - On lsu_rvalid_i, the response is discarded (including lsu_err_i) and the state goes to IDLE.
  - kill_wb_i is ignored.
- No valid instruction (ex_wb_valid_i=0, or killed in IDLE):
  - In IDLE: wb_ready_o=1 and all pulses are 0.
  - An lsu_rvalid_i arriving in IDLE with no load present is ignored. This is a protocol violation that the bench asserts never happens.
- rf_waddr_wb_o = ex_wb_rf_waddr_i always. rf_wdata_wb_o selects lsu_rdata_i when data_req, otherwise ex_wb_rf_wdata_i. rf_we_wb_o is the only qualifier.
- instret_o increments by 1 on each wb_valid_o and wraps modulo 2^64. Exceptions, killed instructions and faulting loads are not counted.

## Timing
- Reset values:
  - state=IDLE, instret_o=0.
  - All combinational outputs follow from the inputs. With ex_wb_valid_i=0 at reset: rf_we_wb_o=0, wb_valid_o=0, lsu_err_o=0, wb_ready_o=1.
- Non-load latency: 0 cycles in WB; the write occurs in the cycle the instruction enters WB.
- Load latency: the write occurs in the cycle of lsu_rvalid_i. A response N cycles after WB entry stalls wb_ready_o low for N cycles.
- instret_o updates on the clock edge after the wb_valid_o cycle.
- Reset mid-WAIT/DRAIN: the state returns to IDLE immediately and the counter clears; the pending response is not tracked.
- At most one outstanding load. A second load cannot enter WB before wb_ready_o=1.

## Test plan
- ALU op: valid, rf_we=1, waddr=5, wdata=0x1234 -> same cycle rf_we_wb_o=1, waddr=5, wdata=0x1234, wb_valid_o=1; instret_o=1 next cycle.
- Load, rvalid 3 cycles after entry, rdata=0xDEADBEEF, waddr=10 -> wb_ready_o=0 for 3 cycles; on the rvalid cycle write 0xDEADBEEF to x10, wb_ready_o=1, then state IDLE.
- Load with rvalid in the entry cycle (zero-wait) -> immediate write, state remains IDLE, wb_ready_o=1.
- Load pc=0x80, rvalid with lsu_err_i=1 -> no write, lsu_err_o=1, lsu_err_pc_o=0x80, instret_o unchanged.
- Load in WAIT, kill_wb_i pulse, rvalid 2 cycles later, next instruction a valid ALU op -> DRAIN holds wb_ready_o=0 and suppresses writes; the response is discarded; then IDLE and the ALU op retires normally.
- instret_o preloaded via 2^64-1 retires (force/hierarchical set), one more retire -> wraps to 0; exc_i=1 instruction -> no write, no count.
